// File: rtl/osf_decimator_pkg.sv
// ============================================================================
// Module      : osf_decimator_pkg
// Description : Shared constants and block addresses for the oversample
//               decimator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package osf_decimator_pkg;

    localparam int c_OSF_N_CHAN  = 8;
    localparam int c_OSF_W_CHAN  = 5;
    localparam int c_OSF_W_DATA  = 18;
    localparam int c_OSF_MAX_OS  = 15;
    localparam int c_OSF_W_OS    = 4;

    // Block register map (16-bit config address space)
    localparam logic [15:0] c_OSF_ID_ADDR   = 16'h0000;
    localparam logic [15:0] c_OSF_STAT_ADDR = 16'h0001;
    localparam logic [15:0] c_OSF_OS_ADDR   = 16'h0010;
    localparam logic [15:0] c_OSF_EN_ADDR   = 16'h0011;

    typedef enum logic [1:0] {
        CFG_NONE = 2'd0,
        CFG_OS   = 2'd1,
        CFG_EN   = 2'd2
    } cfg_sel_e;

endpackage

`default_nettype wire

// File: rtl/osf_round_sat.sv
// ============================================================================
// Module      : osf_round_sat
// Description : Divide an accumulator by 2^os with round-half-up, then
//               saturate to the signed W_DATA output range.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module osf_round_sat #(
    parameter int   W_DATA = 18,
    parameter int   MAX_OS = 15,
    localparam int  W_SH   = (MAX_OS > 0) ? $clog2(MAX_OS + 1) : 1
) (
    input  logic signed [W_DATA+MAX_OS-1:0] acc,
    input  logic        [W_SH-1:0]          os,
    output logic signed [W_DATA-1:0]        data
);

    // One guard bit so adding the rounding constant can never wrap
    localparam int c_W = W_DATA + MAX_OS + 1;

    localparam logic signed [c_W-1:0] c_MAX = {{(c_W-W_DATA+1){1'b0}}, {(W_DATA-1){1'b1}}};
    localparam logic signed [c_W-1:0] c_MIN = {{(c_W-W_DATA+1){1'b1}}, {(W_DATA-1){1'b0}}};

    logic signed [c_W-1:0] w_ext;
    logic signed [c_W-1:0] w_rnd;
    logic signed [c_W-1:0] w_sum;
    logic signed [c_W-1:0] w_shr;

    always_comb begin
        w_ext = {acc[W_DATA+MAX_OS-1], acc};
        w_rnd = '0;
        if (os != '0) begin
            w_rnd = c_W'(1) << (os - 1'b1);
        end
        w_sum = w_ext + w_rnd;
        w_shr = w_sum >>> os;
        if (w_shr > c_MAX) begin
            data = c_MAX[W_DATA-1:0];
        end else if (w_shr < c_MIN) begin
            data = c_MIN[W_DATA-1:0];
        end else begin
            data = w_shr[W_DATA-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/osf_decimator.sv
// ============================================================================
// Module      : osf_decimator
// Description : Multi-channel oversample decimator: per-channel accumulate of
//               2^os samples, rounded average out, 3-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module osf_decimator
    import osf_decimator_pkg::*;
#(
    parameter int                   N_CHAN    = c_OSF_N_CHAN,
    parameter int                   W_CHAN    = c_OSF_W_CHAN,
    parameter int                   W_DATA    = c_OSF_W_DATA,
    parameter int                   MAX_OS    = c_OSF_MAX_OS,
    parameter int                   W_OS      = c_OSF_W_OS,
    parameter int                   W_WR_ADDR = 16,
    parameter int                   W_WR_CHAN = 16,
    parameter int                   W_WR_DATA = 48,
    parameter logic [W_WR_ADDR-1:0] OS_ADDR   = c_OSF_OS_ADDR,
    parameter logic [W_WR_ADDR-1:0] EN_ADDR   = c_OSF_EN_ADDR
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        dv_in,
    input  logic        [W_CHAN-1:0]    chan_in,
    input  logic signed [W_DATA-1:0]    data_in,
    input  logic                        wr_en,
    input  logic        [W_WR_ADDR-1:0] wr_addr,
    input  logic        [W_WR_CHAN-1:0] wr_chan,
    input  logic        [W_WR_DATA-1:0] wr_data,
    output logic                        dv_out,
    output logic        [W_CHAN-1:0]    chan_out,
    output logic signed [W_DATA-1:0]    data_out
);

    localparam int c_W_ACC  = W_DATA + MAX_OS;
    localparam int c_W_CNT  = MAX_OS + 1;
    localparam int c_IW     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int c_RS_OSW = (MAX_OS > 0) ? $clog2(MAX_OS + 1) : 1;

    localparam logic [W_CHAN:0]    c_NCH_IN  = (W_CHAN + 1)'(N_CHAN);
    localparam logic [W_WR_CHAN:0] c_NCH_WR  = (W_WR_CHAN + 1)'(N_CHAN);
    localparam logic [c_W_CNT-1:0] c_CNT_ONE = c_W_CNT'(1);
    localparam logic [W_OS-1:0]    c_OS_MAX  = W_OS'(MAX_OS);

    // Per-channel state
    logic signed [c_W_ACC-1:0] r_acc [N_CHAN];
    logic        [c_W_CNT-1:0] r_cnt [N_CHAN];
    logic        [W_OS-1:0]    r_os  [N_CHAN];
    logic                      r_en  [N_CHAN];

    // Pipeline registers
    logic                      r_s1_vld;
    logic        [W_CHAN-1:0]  r_s1_chan;
    logic signed [W_DATA-1:0]  r_s1_data;
    logic                      r_s2_vld;
    logic        [W_CHAN-1:0]  r_s2_chan;
    logic signed [c_W_ACC-1:0] r_s2_acc;
    logic        [c_W_CNT-1:0] r_s2_cnt;

    logic                      w_in_ok;
    logic        [c_IW-1:0]    w_in_idx;
    logic        [c_IW-1:0]    w_s1_idx;
    logic        [c_IW-1:0]    w_s2_idx;
    logic        [c_IW-1:0]    w_cfg_idx;
    cfg_sel_e                  w_cfg_sel;
    logic                      w_cfg_hit;
    logic        [W_OS-1:0]    w_os_wr;
    logic signed [c_W_ACC-1:0] w_base_acc;
    logic        [c_W_CNT-1:0] w_base_cnt;
    logic signed [c_W_ACC-1:0] w_acc_sum;
    logic        [c_W_CNT-1:0] w_cnt_sum;
    logic        [W_OS-1:0]    w_s3_os;
    logic                      w_s3_close;
    logic                      w_s3_kill;
    logic                      w_s3_wb;
    logic signed [W_DATA-1:0]  w_rs_data;
    logic                      w_unused_bits;

    assign w_in_idx  = chan_in[c_IW-1:0];
    assign w_s1_idx  = r_s1_chan[c_IW-1:0];
    assign w_s2_idx  = r_s2_chan[c_IW-1:0];
    assign w_cfg_idx = wr_chan[c_IW-1:0];
    assign w_in_ok   = dv_in && ({1'b0, chan_in} < c_NCH_IN) && r_en[w_in_idx];

    always_comb begin
        w_cfg_sel = CFG_NONE;
        if (wr_en && ({1'b0, wr_chan} < c_NCH_WR)) begin
            if (wr_addr == OS_ADDR) begin
                w_cfg_sel = CFG_OS;
            end else if (wr_addr == EN_ADDR) begin
                w_cfg_sel = CFG_EN;
            end
        end
    end

    assign w_cfg_hit = (w_cfg_sel != CFG_NONE);
    assign w_os_wr   = (wr_data[W_OS-1:0] > c_OS_MAX) ? c_OS_MAX : wr_data[W_OS-1:0];

    // Stage 3 reads os live; any write that could change it also kills this writeback
    assign w_s3_os    = r_os[w_s2_idx];
    assign w_s3_close = (r_s2_cnt == (c_CNT_ONE << w_s3_os));
    assign w_s3_kill  = w_cfg_hit && (w_cfg_idx == w_s2_idx);
    assign w_s3_wb    = r_s2_vld && !w_s3_kill;

    // Accumulate: base comes from a same-cycle clear, the in-flight stage-3 result, or the array
    always_comb begin
        w_base_acc = r_acc[w_s1_idx];
        w_base_cnt = r_cnt[w_s1_idx];
        if (w_cfg_hit && (w_cfg_idx == w_s1_idx)) begin
            w_base_acc = '0;
            w_base_cnt = '0;
        end else if (r_s2_vld && (r_s2_chan == r_s1_chan)) begin
            w_base_acc = w_s3_close ? '0 : r_s2_acc;
            w_base_cnt = w_s3_close ? '0 : r_s2_cnt;
        end
        w_acc_sum = w_base_acc + c_W_ACC'(r_s1_data);
        w_cnt_sum = w_base_cnt + c_CNT_ONE;
    end

    osf_round_sat #(
        .W_DATA (W_DATA),
        .MAX_OS (MAX_OS)
    ) u_round_sat (
        .acc  (r_s2_acc),
        .os   (w_s3_os[c_RS_OSW-1:0]),
        .data (w_rs_data)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s1_vld  <= 1'b0;
            r_s1_chan <= '0;
            r_s1_data <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_chan <= '0;
            r_s2_acc  <= '0;
            r_s2_cnt  <= '0;
            dv_out    <= 1'b0;
            chan_out  <= '0;
            data_out  <= '0;
        end else begin
            r_s1_vld  <= w_in_ok;
            r_s1_chan <= chan_in;
            r_s1_data <= data_in;
            r_s2_vld  <= r_s1_vld;
            r_s2_chan <= r_s1_chan;
            r_s2_acc  <= w_acc_sum;
            r_s2_cnt  <= w_cnt_sum;
            dv_out    <= w_s3_wb && w_s3_close;
            if (w_s3_wb && w_s3_close) begin
                chan_out <= r_s2_chan;
                data_out <= w_rs_data;
            end
        end
    end

    // Config writes come last so they override a writeback to the same channel
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < N_CHAN; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
                r_os[i]  <= '0;
                r_en[i]  <= 1'b1;
            end
        end else begin
            if (w_s3_wb) begin
                r_acc[w_s2_idx] <= w_s3_close ? '0 : r_s2_acc;
                r_cnt[w_s2_idx] <= w_s3_close ? '0 : r_s2_cnt;
            end
            if (w_cfg_hit) begin
                r_acc[w_cfg_idx] <= '0;
                r_cnt[w_cfg_idx] <= '0;
                if (w_cfg_sel == CFG_OS) begin
                    r_os[w_cfg_idx] <= w_os_wr;
                end
                if (w_cfg_sel == CFG_EN) begin
                    r_en[w_cfg_idx] <= wr_data[0];
                end
            end
        end
    end

    assign w_unused_bits = ^{wr_data, w_s3_os};

endmodule

`default_nettype wire

// File: tb/tb_osf_decimator.sv
// ============================================================================
// Module      : tb_osf_decimator
// Description : Directed and random stimulus for osf_decimator against a
//               per-channel running-sum reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_osf_decimator;

    localparam int          N_CHAN = 8;
    localparam logic [15:0] OS_A   = 16'h0010;
    localparam logic [15:0] EN_A   = 16'h0011;
    localparam longint      D_MAX  = 131071;
    localparam longint      D_MIN  = -131072;

    typedef struct {
        int     due;
        int     ch;
        longint val;
    } exp_t;

    logic               clk_in  = 1'b0;
    logic               rst_in  = 1'b0;
    logic               dv_in   = 1'b0;
    logic        [4:0]  chan_in = '0;
    logic signed [17:0] data_in = '0;
    logic               wr_en   = 1'b0;
    logic        [15:0] wr_addr = '0;
    logic        [15:0] wr_chan = '0;
    logic        [47:0] wr_data = '0;
    logic               dv_out;
    logic        [4:0]  chan_out;
    logic signed [17:0] data_out;

    always #5 clk_in = ~clk_in;

    osf_decimator dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .dv_in    (dv_in),
        .chan_in  (chan_in),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_chan  (wr_chan),
        .wr_data  (wr_data),
        .dv_out   (dv_out),
        .chan_out (chan_out),
        .data_out (data_out)
    );

    // Reference state: running sum and sample count of the open window per channel
    longint m_sum [N_CHAN];
    int     m_cnt [N_CHAN];
    int     m_os  [N_CHAN];
    bit     m_en  [N_CHAN];
    exp_t   exp_q [$];
    int     cyc       = 0;
    longint last_data = 0;
    int     last_chan = 0;
    int     n_assert  = 0;
    int     n_fail    = 0;

    function automatic longint ref_avg(input longint sum, input int os);
        longint d, num, q;
        d   = longint'(1) << os;
        num = sum + ((os > 0) ? d / 2 : 0);
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        if (q > D_MAX) q = D_MAX;
        if (q < D_MIN) q = D_MIN;
        return q;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CHAN; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
            m_os[i]  = 0;
            m_en[i]  = 1'b1;
        end
        exp_q.delete();
        last_data = 0;
        last_chan = 0;
    endtask

    task automatic step(input bit dv, input int ch, input longint d, input bit wr,
                        input logic [15:0] addr, input int wch, input longint wd);
        bit          take;
        logic [47:0] wdv;
        wdv     = 48'(wd);
        dv_in   = dv;
        chan_in = 5'(ch);
        data_in = 18'(d);
        wr_en   = wr;
        wr_addr = addr;
        wr_chan = 16'(wch);
        wr_data = wdv;
        take = 1'b0;
        if (dv && ch >= 0 && ch < N_CHAN) take = m_en[ch];
        if (wr && wch >= 0 && wch < N_CHAN && (addr == OS_A || addr == EN_A)) begin
            m_sum[wch] = 0;
            m_cnt[wch] = 0;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].ch == wch && exp_q[i].due == cyc + 1) exp_q.delete(i);
            end
            if (addr == OS_A) m_os[wch] = (int'(wdv[3:0]) > 15) ? 15 : int'(wdv[3:0]);
            else              m_en[wch] = wdv[0];
        end
        if (take) begin
            m_sum[ch] += d;
            m_cnt[ch]++;
            if (m_cnt[ch] == (1 << m_os[ch])) begin
                exp_q.push_back('{cyc + 3, ch, ref_avg(m_sum[ch], m_os[ch])});
                m_sum[ch] = 0;
                m_cnt[ch] = 0;
            end
        end
        @(posedge clk_in);
        cyc++;
        #1;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            chk("dv_out", dv_out, 1);
            chk("chan_out", chan_out, exp_q[0].ch);
            chk("data_out", data_out, exp_q[0].val);
            last_data = exp_q[0].val;
            last_chan = exp_q[0].ch;
            void'(exp_q.pop_front());
        end else begin
            chk("dv_out_idle", dv_out, 0);
            chk("data_out_hold", data_out, last_data);
            chk("chan_out_hold", chan_out, last_chan);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0, 16'h0, 0, 0);
    endtask

    task automatic sample(input int ch, input longint d);
        step(1'b1, ch, d, 1'b0, 16'h0, 0, 0);
    endtask

    task automatic cfg(input logic [15:0] addr, input int ch, input longint v);
        step(1'b0, 0, 0, 1'b1, addr, ch, v);
    endtask

    task automatic rand_step();
        logic signed [17:0] r;
        int                 sel;
        r   = 18'($urandom);
        sel = int'($urandom_range(0, 15));
        if (sel == 0) r = 18'h1FFFF;
        if (sel == 1) r = 18'h20000;
        step($urandom_range(0, 3) != 0, int'($urandom_range(0, 9)), longint'(r), 1'b0, 16'h0, 0, 0);
    endtask

    initial begin
        model_reset();
        #2 rst_in = 1'b1;
        #1;
        chk("reset_dv_out", dv_out, 0);
        chk("reset_chan_out", chan_out, 0);
        chk("reset_data_out", data_out, 0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Pass-through at os=0
        sample(2, 5);
        sample(2, -7);
        idle(4);

        // Decimate by 4 with rounding, then a second window
        cfg(OS_A, 1, 2);
        idle(1);
        for (int i = 1; i <= 4; i++) sample(1, i);
        idle(4);
        repeat (4) sample(1, 8);
        idle(4);

        // Interleaved channels with back-to-back forwarding
        cfg(OS_A, 0, 1);
        cfg(OS_A, 1, 1);
        idle(1);
        sample(0, 10);
        sample(0, 20);
        sample(1, -4);
        sample(1, -6);
        idle(4);

        // Full-scale average must not overflow
        cfg(OS_A, 6, 1);
        idle(1);
        sample(6, 131071);
        sample(6, 131071);
        idle(4);

        // os change mid-window discards the partial window
        cfg(OS_A, 4, 3);
        idle(1);
        repeat (5) sample(4, longint'($urandom_range(0, 50)));
        idle(4);
        cfg(OS_A, 4, 1);
        idle(1);
        sample(4, 6);
        sample(4, 6);
        idle(4);

        // Disabled and out-of-range channels are dropped
        cfg(EN_A, 3, 0);
        idle(1);
        sample(3, 100);
        sample(3, -5);
        sample(9, 1);
        sample(31, 2);
        idle(4);

        // Unmatched address and out-of-range write channels are ignored
        sample(0, 40);
        idle(3);
        cfg(16'h0012, 0, 5);
        cfg(OS_A, 8, 3);
        cfg(EN_A, 12, 0);
        idle(1);
        sample(0, 61);
        idle(4);

        // Only the low os bits of wr_data matter
        cfg(OS_A, 1, 64'h0000_FFFF_FFFF_FFF3);
        idle(1);
        repeat (8) sample(1, longint'($urandom_range(0, 1000)) - 500);
        idle(4);

        // Config write to a channel whose result is in stage 3 suppresses it
        idle(2);
        sample(5, 77);
        idle(1);
        cfg(EN_A, 5, 1);
        idle(1);
        sample(5, 33);
        idle(4);

        // Random traffic over mixed ratios
        for (int ch = 0; ch < N_CHAN; ch++) cfg(OS_A, ch, longint'($urandom_range(0, 3)));
        cfg(EN_A, 3, 1);
        cfg(EN_A, 7, 0);
        idle(1);
        repeat (400) rand_step();

        // Asynchronous reset mid-stream
        repeat (3) rand_step();
        #3;
        rst_in = 1'b1;
        dv_in  = 1'b0;
        wr_en  = 1'b0;
        #1;
        chk("midrst_dv_out", dv_out, 0);
        chk("midrst_chan_out", chan_out, 0);
        chk("midrst_data_out", data_out, 0);
        model_reset();
        idle(2);
        rst_in = 1'b0;
        sample(2, 5);
        sample(1, -100);
        sample(7, 1234);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/osf_decimator.md
OSF_DECIMATOR -- requirements
Module: osf_decimator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_CHAN, 8, number of independent channels.
- W_CHAN, 5, channel-index width; N_CHAN <= 2^W_CHAN.
- W_DATA, 18, signed sample width.
- MAX_OS, 15, largest allowed log2 oversample ratio.
- W_OS, 4, width of the os field; 2^W_OS > MAX_OS.
- W_WR_ADDR, 16, config address width.
- W_WR_CHAN, 16, config channel width.
- W_WR_DATA, 48, config data width.
- OS_ADDR, 16'h0010, address of the per-channel os register.
- EN_ADDR, 16'h0011, address of the per-channel enable register.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_in, in, 1, sole clock.
- rst_in, in, 1, reset: asynchronous, active-high.
- dv_in, in, 1, input sample valid.
- chan_in, in, W_CHAN, input channel.
- data_in, in, W_DATA signed, input sample.
- wr_en, in, 1, config write strobe, sampled on clk_in.
- wr_addr, in, W_WR_ADDR, config address.
- wr_chan, in, W_WR_CHAN, config channel.
- wr_data, in, W_WR_DATA, config data.
- dv_out, out, 1, output valid.
- chan_out, out, W_CHAN, output channel.
- data_out, out, W_DATA signed, averaged sample.

Function
REQ-003 Each channel SHALL hold the following state:
- accumulator, width W_DATA+MAX_OS, signed;
- sample count, width MAX_OS+1;
- os;
- enable.

REQ-004 The pipeline SHALL be 3 stages: fetch, accumulate, divide/writeback. Latency SHALL be exactly 3 clk_in cycles from dv_in to dv_out.

REQ-005 Samples on a channel with enable=0 or chan_in >= N_CHAN SHALL be dropped and SHALL leave all state unchanged.

REQ-006 The block SHALL accept one sample per cycle with no stall. Consecutive samples to the same channel SHALL forward the in-flight accumulator/count, so no sample is ever lost.

REQ-007 A window SHALL close when the post-increment count equals 2^os. On close:
- dv_out=1;
- accumulator and count cleared.
Otherwise dv_out=0 and the new accumulator/count are written back.

REQ-008 Division SHALL be arithmetic right shift by os with round-half-up: add 2^(os-1) before shifting when os>0.

REQ-009 With os=0, every valid sample SHALL pass through unchanged with latency 3.

REQ-010 The rounded result SHALL saturate to [-2^(W_DATA-1), 2^(W_DATA-1)-1].

REQ-011 chan_out SHALL equal the sample's channel. data_out SHALL hold its last value when dv_out=0.

REQ-012 On a config write (wr_en=1, matching wr_addr, wr_chan < N_CHAN):
- OS_ADDR: os <= min(wr_data[W_OS-1:0], MAX_OS);
- EN_ADDR: enable <= wr_data[0].
The write SHALL take effect on the next clk_in edge.

REQ-013 Any config write SHALL clear that channel's accumulator and count. A same-cycle stage-3 writeback to that channel SHALL be discarded and SHALL NOT assert dv_out.

REQ-014 Writes with an unmatched address or out-of-range channel SHALL be ignored.

Reset
REQ-015 While rst_in=1, asynchronously:
- dv_out, chan_out, data_out and all pipeline valids SHALL be 0;
- all accumulators and counts SHALL be 0;
- os SHALL be 0 and enable SHALL be 1 for all channels.

REQ-016 Samples in flight when reset asserts SHALL be discarded. The first dv_out after release SHALL come from a sample entered at least 1 cycle after release.

Structure
REQ-017 OS_ADDR, EN_ADDR and the channel/data width constants SHALL live in the shared parameters package, alongside the other block addresses.

REQ-018 Divide/round/saturate SHALL be one combinational sub-module, osf_round_sat, parametrised by W_DATA and MAX_OS.

REQ-019 Per-channel state SHALL be register arrays, not vendor RAM primitives.

Verification
REQ-020 Pass-through: os=0, chan 2, samples 5, -7 -> dv_out on each, data_out 5 then -7, latency 3.

REQ-021 Decimate:
- os=2, chan 1, samples 1,2,3,4 back-to-back -> single dv_out, data_out 3 (10/4 = 2.5 rounds up), after the 4th sample + 3 cycles.
- Next 4 samples of 8 -> 8.

REQ-022 Interleave/hazard: os=1 on chans 0 and 1; stream ch0:10, ch0:20, ch1:-4, ch1:-6 -> outputs ch0=15, ch1=-5, no loss.

REQ-023 Saturation: W_DATA=18, os=1, two samples 131071 -> data_out 131071, not overflowed.

REQ-024 Config mid-window: os=3, 5 samples on ch 4, then write os=1 -> no output; the next 2 samples of 6 -> 6.

REQ-025 Reset/enable:
- Assert rst_in mid-stream -> outputs 0 immediately; after release os=0 pass-through.
- enable=0 on ch 3 -> ch 3 samples produce no dv_out.
